// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//
// Measurement sequencer for the frequency counter. Takes debounced key levels,
// cycles the gate-time range, and runs the counter datapath through
// clear -> gate -> latch -> dead time. The hold key freezes the displayed
// result by stopping new measurements from starting.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous reset, active-low
//   key_range  in   debounced range key level (idle high, pressed low)
//   key_hold   in   debounced hold key level (idle high, pressed low)
//   key_down   in   debounced range-down key level (only with RANGE_DOWN_EN)
//   cnt_clr    out  one-cycle pulse that clears the datapath counter
//   gate_en    out  high for exactly the selected gate length
//   cnt_latch  out  one-cycle pulse that latches the count into the result
//   range_sel  out  current range, 0..2
//   hold_act   out  hold mode active (LED)
//   busy       out  high in CLEAR, GATE and LATCH
//
// Optional feature: define RANGE_DOWN_EN to add key_down, which steps the
// range downwards. Pressing both range keys together leaves the range alone
// but still restarts the measurement.
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
   parameter int unsigned GATE_CYC0 = 50_000_000,
   parameter int unsigned GATE_CYC1 = 5_000_000,
   parameter int unsigned GATE_CYC2 = 500_000,
   parameter int unsigned DEAD_CYC  = 1000,
   parameter int unsigned CNT_W     = 32
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_range,
   input  logic       key_hold,
`ifdef RANGE_DOWN_EN
   input  logic       key_down,
`endif
   output logic       cnt_clr,
   output logic       gate_en,
   output logic       cnt_latch,
   output logic [1:0] range_sel,
   output logic       hold_act,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_GATE, S_LATCH, S_DEAD, S_PAUSE
   } state_t;

   localparam logic [CNT_W-1:0] GATE_LOAD0 = CNT_W'(GATE_CYC0 - 1);
   localparam logic [CNT_W-1:0] GATE_LOAD1 = CNT_W'(GATE_CYC1 - 1);
   localparam logic [CNT_W-1:0] GATE_LOAD2 = CNT_W'(GATE_CYC2 - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       range_q, range_d;
   logic             hold_q, hold_d;

   // Key level sample plus one cycle of history for falling-edge detection.
   logic key_range_q, key_range_hist_q;
   logic key_hold_q,  key_hold_hist_q;
   logic range_up_ev, hold_ev, range_ev;

   logic cnt_clr_q, gate_en_q, cnt_latch_q, busy_q;
   logic [CNT_W-1:0] gate_load;

   assign range_up_ev = key_range_hist_q & ~key_range_q;
   assign hold_ev     = key_hold_hist_q  & ~key_hold_q;

`ifdef RANGE_DOWN_EN
   logic key_down_q, key_down_hist_q;
   logic range_dn_ev;
   assign range_dn_ev = key_down_hist_q & ~key_down_q;
   assign range_ev    = range_up_ev | range_dn_ev;
`else
   assign range_ev    = range_up_ev;
`endif

   always_comb begin
      case (range_q)
         2'd0:    gate_load = GATE_LOAD0;
         2'd1:    gate_load = GATE_LOAD1;
         default: gate_load = GATE_LOAD2;
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path through
      // this block leaves a variable unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      range_d = range_q;
      hold_d  = hold_q ^ hold_ev;

`ifdef RANGE_DOWN_EN
      if (range_up_ev && !range_dn_ev)
         range_d = (range_q == 2'd2) ? 2'd0 : range_q + 2'd1;
      else if (range_dn_ev && !range_up_ev)
         range_d = (range_q == 2'd0) ? 2'd2 : range_q - 2'd1;
`else
      if (range_up_ev)
         range_d = (range_q == 2'd2) ? 2'd0 : range_q + 2'd1;
`endif

      if (range_ev) begin
         // Abort whatever is in flight; a pending hold keeps us parked.
         state_d = hold_d ? S_PAUSE : S_CLEAR;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_CLEAR;
            S_CLEAR: begin
               cnt_d   = gate_load;
               state_d = S_GATE;
            end
            S_GATE: begin
               if (cnt_q == '0) state_d = S_LATCH;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_LATCH: begin
               if (hold_d) begin
                  state_d = S_PAUSE;
               end else begin
                  cnt_d   = DEAD_LOAD;
                  state_d = S_DEAD;
               end
            end
            S_DEAD: begin
               if (cnt_q == '0) state_d = hold_d ? S_PAUSE : S_CLEAR;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_PAUSE: if (!hold_d) state_d = S_CLEAR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         range_q          <= 2'd0;
         hold_q           <= 1'b0;
         // History resets to the idle level, so an undriven key at power-up
         // cannot fake a press after reset.
         key_range_q      <= 1'b1;
         key_range_hist_q <= 1'b1;
         key_hold_q       <= 1'b1;
         key_hold_hist_q  <= 1'b1;
`ifdef RANGE_DOWN_EN
         key_down_q       <= 1'b1;
         key_down_hist_q  <= 1'b1;
`endif
         cnt_clr_q        <= 1'b0;
         gate_en_q        <= 1'b0;
         cnt_latch_q      <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every register samples the
         // pre-edge values and update order inside this block is irrelevant.
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         range_q          <= range_d;
         hold_q           <= hold_d;
         key_range_q      <= key_range;
         key_range_hist_q <= key_range_q;
         key_hold_q       <= key_hold;
         key_hold_hist_q  <= key_hold_q;
`ifdef RANGE_DOWN_EN
         key_down_q       <= key_down;
         key_down_hist_q  <= key_down_q;
`endif
         // Outputs are decoded from the next state so they are registered
         // yet line up with the state they belong to.
         cnt_clr_q        <= (state_d == S_CLEAR);
         gate_en_q        <= (state_d == S_GATE);
         cnt_latch_q      <= (state_d == S_LATCH);
         busy_q           <= (state_d == S_CLEAR) || (state_d == S_GATE) ||
                             (state_d == S_LATCH);
      end
   end

   assign cnt_clr   = cnt_clr_q;
   assign gate_en   = gate_en_q;
   assign cnt_latch = cnt_latch_q;
   assign range_sel = range_q;
   assign hold_act  = hold_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_ctrl
//
// Self-checking bench for freq_gate_ctrl with short gate/dead lengths. The
// reference model describes a measurement as a timeline: a clear at its start
// edge, then the gate, the latch and the dead time at fixed offsets from that
// start.
// -----------------------------------------------------------------------------
module tb_freq_gate_ctrl;

   localparam int G0 = 20;
   localparam int G1 = 12;
   localparam int G2 = 7;
   localparam int DC = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       key_range = 1'b1;
   logic       key_hold = 1'b1;
   logic       cnt_clr, gate_en, cnt_latch, hold_act, busy;
   logic [1:0] range_sel;
   logic [6:0] dut_vec;

   int n_vec = 0;
   int n_err = 0;

   always #5 sys_clk = ~sys_clk;

   freq_gate_ctrl #(
      .GATE_CYC0(G0), .GATE_CYC1(G1), .GATE_CYC2(G2), .DEAD_CYC(DC), .CNT_W(8)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .key_range (key_range),
      .key_hold  (key_hold),
      .cnt_clr   (cnt_clr),
      .gate_en   (gate_en),
      .cnt_latch (cnt_latch),
      .range_sel (range_sel),
      .hold_act  (hold_act),
      .busy      (busy)
   );

   assign dut_vec = {cnt_clr, gate_en, cnt_latch, range_sel, hold_act, busy};

   // ---------------------------------------------------------------- model
   typedef enum {M_BOOT, M_RUN, M_PAUSE} mmode_e;
   mmode_e m_mode;
   int     m_s, m_r, n_edge;
   bit     m_h, kr1, kr2, kh1, kh2;

   function automatic int gate_len(input int r);
      case (r)
         0:       return G0;
         1:       return G1;
         default: return G2;
      endcase
   endfunction

   function automatic void model_reset();
      m_mode = M_BOOT; m_s = 0; m_r = 0; m_h = 0; n_edge = 0;
      kr1 = 1; kr2 = 1; kh1 = 1; kh2 = 1;
   endfunction

   // One clock edge; kr/kh are the key levels present at that edge.
   function automatic void model_step(input logic kr, input logic kh);
      bit rev, hev;
      int a, g;
      rev = kr2 & ~kr1;
      hev = kh2 & ~kh1;
      kr2 = kr1; kr1 = kr;
      kh2 = kh1; kh1 = kh;
      n_edge++;
      if (hev) m_h = ~m_h;
      if (rev) m_r = (m_r + 1) % 3;
      if (m_mode == M_BOOT) begin
         m_mode = M_RUN; m_s = n_edge;
      end else if (rev) begin
         if (m_h) m_mode = M_PAUSE;
         else begin m_mode = M_RUN; m_s = n_edge; end
      end else if (m_mode == M_RUN) begin
         a = n_edge - m_s;
         g = gate_len(m_r);
         if (a == g + 2 && m_h) m_mode = M_PAUSE;
         else if (a == g + 2 + DC) begin
            if (m_h) m_mode = M_PAUSE;
            else     m_s = n_edge;
         end
      end else if (!m_h) begin
         m_mode = M_RUN; m_s = n_edge;
      end
   endfunction

   function automatic logic [6:0] model_out();
      int a, g;
      logic c, ge, l, b;
      logic [1:0] r;
      c = 0; ge = 0; l = 0; b = 0;
      r = m_r[1:0];
      if (m_mode == M_RUN) begin
         a = n_edge - m_s;
         g = gate_len(m_r);
         c  = (a == 0);
         ge = (a >= 1) && (a <= g);
         l  = (a == g + 1);
         b  = (a <= g + 1);
      end
      return {c, ge, l, r, m_h, b};
   endfunction

   task automatic step();
      @(posedge sys_clk);
      model_step(key_range, key_hold);
      #1;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      #12;
      n_vec++;
      if (dut_vec !== 7'b0) begin
         n_err++; $display("FAIL reset_state dut=%b exp=%b", dut_vec, 7'b0);
      end
      @(negedge sys_clk);
      sys_rst = 1'b1;
      model_reset();
      step();
      n_vec++;
      if (dut_vec !== model_out()) begin
         n_err++; $display("FAIL first_clear dut=%b exp=%b", dut_vec, model_out());
      end
   endtask

   task automatic test_period();
      int clr_prev, gate_cnt, periods;
      clr_prev = n_edge; gate_cnt = 0; periods = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL period e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
         end
         if (gate_en) gate_cnt++;
         if (cnt_clr && periods == 0) begin
            periods++;
            n_vec++;
            if (n_edge - clr_prev != 1 + G0 + 1 + DC) begin
               n_err++; $display("FAIL period_len got=%0d exp=%0d", n_edge - clr_prev, 1 + G0 + 1 + DC);
            end
            n_vec++;
            if (gate_cnt != G0) begin
               n_err++; $display("FAIL gate_len got=%0d exp=%0d", gate_cnt, G0);
            end
         end
      end
   endtask

   task automatic wait_gate(input string name);
      int k = 0;
      while (!gate_en && k < 100) begin
         step(); k++;
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL %s_wait e%0d dut=%b exp=%b", name, n_edge, dut_vec, model_out());
         end
      end
      n_vec++;
      if (!gate_en) begin n_err++; $display("FAIL %s_timeout gate_en got=0 exp=1", name); end
   endtask

   task automatic wait_latch(input string name);
      int k = 0;
      while (!cnt_latch && k < 100) begin
         step(); k++;
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL %s_wait e%0d dut=%b exp=%b", name, n_edge, dut_vec, model_out());
         end
      end
      n_vec++;
      if (!cnt_latch) begin n_err++; $display("FAIL %s_timeout cnt_latch got=0 exp=1", name); end
   endtask

   task automatic test_range_abort();
      int gcnt, latches, k;
      wait_gate("abort");
      repeat (5) step();
      key_range = 1'b0; step();
      key_range = 1'b1; step();
      n_vec++;
      if (range_sel !== 2'd1 || gate_en !== 1'b0 || cnt_latch !== 1'b0) begin
         n_err++; $display("FAIL abort range=%0d gate=%b latch=%b exp range=1 gate=0 latch=0",
                           range_sel, gate_en, cnt_latch);
      end
      gcnt = 0; latches = 0; k = 0;
      while (!cnt_latch && k < 60) begin
         step(); k++;
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL abort_run e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
         end
         if (gate_en) gcnt++;
      end
      n_vec++;
      if (gcnt != G1) begin n_err++; $display("FAIL abort_gate_len got=%0d exp=%0d", gcnt, G1); end
   endtask

   task automatic test_range_keys();
      int r_exp;
      for (int p = 0; p < 3; p++) begin
         r_exp = (m_r + 1) % 3;
         key_range = 1'b0; step();
         key_range = 1'b1;
         for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if (dut_vec !== model_out()) begin
               n_err++; $display("FAIL range_press e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
            end
         end
         n_vec++;
         if (range_sel !== 2'(r_exp)) begin
            n_err++; $display("FAIL range_step got=%0d exp=%0d", range_sel, r_exp);
         end
      end
      r_exp = (m_r + 1) % 3;
      key_range = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL range_held e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
         end
      end
      key_range = 1'b1;
      repeat (3) step();
      n_vec++;
      if (range_sel !== 2'(r_exp)) begin
         n_err++; $display("FAIL range_no_repeat got=%0d exp=%0d", range_sel, r_exp);
      end
   endtask

   task automatic test_hold();
      int clrs;
      wait_gate("hold");
      repeat (3) step();
      key_hold = 1'b0; step();
      key_hold = 1'b1; step();
      n_vec++;
      if (hold_act !== 1'b1 || gate_en !== 1'b1) begin
         n_err++; $display("FAIL hold_on hold=%b gate=%b exp hold=1 gate=1", hold_act, gate_en);
      end
      wait_latch("hold");
      clrs = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL hold_pause e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
         end
         if (cnt_clr || busy) clrs++;
      end
      n_vec++;
      if (clrs != 0) begin n_err++; $display("FAIL hold_frozen active_cycles got=%0d exp=0", clrs); end
      key_hold = 1'b0; step();
      key_hold = 1'b1; step();
      n_vec++;
      if (cnt_clr !== 1'b1 || hold_act !== 1'b0) begin
         n_err++; $display("FAIL hold_release clr=%b hold=%b exp clr=1 hold=0", cnt_clr, hold_act);
      end
   endtask

   task automatic test_simul();
      int r_exp, clrs;
      wait_latch("simul");
      r_exp = (m_r + 1) % 3;
      key_range = 1'b0; key_hold = 1'b0; step();
      key_range = 1'b1; key_hold = 1'b1; step();
      n_vec++;
      if (range_sel !== 2'(r_exp) || hold_act !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL simul range=%0d hold=%b busy=%b exp range=%0d hold=1 busy=0",
                           range_sel, hold_act, busy, r_exp);
      end
      clrs = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL simul_pause e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
         end
         if (cnt_clr) clrs++;
      end
      n_vec++;
      if (clrs != 0) begin n_err++; $display("FAIL simul_no_clear got=%0d exp=0", clrs); end
      key_hold = 1'b0; step();
      key_hold = 1'b1; step();
      n_vec++;
      if (dut_vec !== model_out() || cnt_clr !== 1'b1) begin
         n_err++; $display("FAIL simul_release dut=%b exp=%b", dut_vec, model_out());
      end
   endtask

   task automatic test_async_reset();
      wait_gate("areset");
      repeat (3) step();
      #2;
      sys_rst = 1'b0;
      #1;
      n_vec++;
      if (dut_vec !== 7'b0) begin
         n_err++; $display("FAIL async_reset dut=%b exp=%b", dut_vec, 7'b0);
      end
      @(posedge sys_clk); #1;
      n_vec++;
      if (dut_vec !== 7'b0) begin
         n_err++; $display("FAIL reset_held dut=%b exp=%b", dut_vec, 7'b0);
      end
      @(negedge sys_clk);
      sys_rst = 1'b1;
      model_reset();
      for (int i = 0; i < 30; i++) begin
         step();
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL restart e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 24) == 0) key_range = ~key_range;
         if ($urandom_range(0, 59) == 0) key_hold = ~key_hold;
         step();
         n_vec++;
         if (dut_vec !== model_out()) begin
            n_err++; $display("FAIL random e%0d dut=%b exp=%b", n_edge, dut_vec, model_out());
         end
      end
      key_range = 1'b1;
      key_hold  = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_period();
      test_range_abort();
      test_range_keys();
      test_hold();
      test_simul();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
